// File: rtl/bus_pkg.sv
// Shared types and helpers for the 6502-side bus access controller.
// Region tables are packed vectors; the helpers pull out one window's field.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE,
        HOLD
    } state_t;

    localparam int WAIT_W = 4;
    localparam int VEC_W = 512;
    localparam logic [7:0] UNMAPPED_DATA = 8'hFF;

    function automatic logic [31:0] field(input logic [VEC_W-1:0] vec, input int idx, input int w);
        logic [31:0] msk;
        msk = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return 32'(vec >> (idx * w)) & msk;
    endfunction

    function automatic logic [31:0] region_base(input logic [VEC_W-1:0] vec, input int idx, input int addr_w);
        return field(vec, idx, addr_w);
    endfunction

    function automatic logic [31:0] region_mask(input logic [VEC_W-1:0] vec, input int idx, input int addr_w);
        return field(vec, idx, addr_w);
    endfunction

    function automatic logic [WAIT_W-1:0] region_wait(input logic [VEC_W-1:0] vec, input int idx);
        return WAIT_W'(field(vec, idx, WAIT_W));
    endfunction

endpackage

// File: rtl/bus_access_ctrl_addr_region_match.sv
// Combinational priority decoder: address to one-hot window match.
// Overlapping windows resolve to the lowest index.
module addr_region_match
    import bus_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int NUM_REGIONS = 4,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = '0
) (
    input  logic [ADDR_W-1:0]      addr,
    output logic [NUM_REGIONS-1:0] match,
    output logic                   hit
);

    logic [NUM_REGIONS-1:0] raw;

    for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_win
        localparam logic [ADDR_W-1:0] BASE = ADDR_W'(region_base(VEC_W'(REGION_BASE), i, ADDR_W));
        localparam logic [ADDR_W-1:0] MASK = ADDR_W'(region_mask(VEC_W'(REGION_MASK), i, ADDR_W));
        localparam logic [NUM_REGIONS-1:0] LOWER = NUM_REGIONS'((64'd1 << i) - 64'd1);

        assign raw[i] = (addr & MASK) == (BASE & MASK);
        // a window only wins if no lower-index window also matches
        assign match[i] = raw[i] && ((raw & LOWER) == '0);
    end

    assign hit = |raw;

endmodule

// File: rtl/bus_access_ctrl.sv
// Per-access bus controller: decodes the CPU address at the phi_0 rise, inserts
// the window's wait states via RDY, then strobes the write or captures read data.
module bus_access_ctrl
    import bus_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int NUM_REGIONS = 4,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = '0,
    parameter logic [NUM_REGIONS*4-1:0] REGION_WAIT = '0,
    parameter logic [NUM_REGIONS-1:0] REGION_RO = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   phi_0,
    input  logic [ADDR_W-1:0]      addr,
    input  logic                   cpu_rw,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic [NUM_REGIONS-1:0] cs,
    output logic                   mem_oe,
    output logic                   mem_we,
    output logic                   rdy,
    output logic [DATA_W-1:0]      cpu_rdata,
    output logic                   bus_err
);

    logic [NUM_REGIONS-1:0] match;
    logic                   hit;
    logic [WAIT_W-1:0]      wait_acc [NUM_REGIONS+1];
    logic [WAIT_W-1:0]      wait_sel;
    logic                   ro_sel;

    addr_region_match #(
        .ADDR_W      (ADDR_W),
        .NUM_REGIONS (NUM_REGIONS),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK)
    ) u_match (
        .addr  (addr),
        .match (match),
        .hit   (hit)
    );

    assign wait_acc[0] = '0;
    for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_wait
        localparam logic [WAIT_W-1:0] WAIT_I = region_wait(VEC_W'(REGION_WAIT), i);
        assign wait_acc[i+1] = wait_acc[i] | (match[i] ? WAIT_I : '0);
    end
    assign wait_sel = wait_acc[NUM_REGIONS];
    assign ro_sel   = |(match & REGION_RO);

    state_t                 state, state_nxt;
    logic                   phi_q;
    logic                   rw_q, rw_nxt;
    logic                   hit_q, hit_nxt;
    logic                   ro_q, ro_nxt;
    logic [WAIT_W-1:0]      cnt, cnt_nxt;
    logic [NUM_REGIONS-1:0] cs_nxt;
    logic                   oe_nxt, we_nxt, rdy_nxt, err_nxt;
    logic [DATA_W-1:0]      rdata_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            phi_q     <= 1'b0;
            rw_q      <= 1'b1;
            hit_q     <= 1'b0;
            ro_q      <= 1'b0;
            cnt       <= '0;
            cs        <= '0;
            mem_oe    <= 1'b0;
            mem_we    <= 1'b0;
            rdy       <= 1'b1;
            bus_err   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            state     <= state_nxt;
            phi_q     <= phi_0;
            rw_q      <= rw_nxt;
            hit_q     <= hit_nxt;
            ro_q      <= ro_nxt;
            cnt       <= cnt_nxt;
            cs        <= cs_nxt;
            mem_oe    <= oe_nxt;
            mem_we    <= we_nxt;
            rdy       <= rdy_nxt;
            bus_err   <= err_nxt;
            cpu_rdata <= rdata_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rw_nxt    = rw_q;
        hit_nxt   = hit_q;
        ro_nxt    = ro_q;
        cnt_nxt   = cnt;
        cs_nxt    = cs;
        oe_nxt    = mem_oe;
        we_nxt    = mem_we;
        rdy_nxt   = rdy;
        err_nxt   = bus_err;
        rdata_nxt = cpu_rdata;
        case (state)
            IDLE: begin
                if (phi_0 && !phi_q) begin
                    rw_nxt    = cpu_rw;
                    hit_nxt   = hit;
                    ro_nxt    = ro_sel;
                    cs_nxt    = match;
                    oe_nxt    = cpu_rw && hit;
                    cnt_nxt   = wait_sel;
                    rdy_nxt   = 1'b0;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    if (rw_q) begin
                        rdata_nxt = hit_q ? mem_rdata : DATA_W'(UNMAPPED_DATA);
                    end
                    if (!hit_q || (!rw_q && ro_q)) begin
                        err_nxt = 1'b1;
                    end else if (!rw_q) begin
                        we_nxt = 1'b1;
                    end
                    rdy_nxt   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                we_nxt    = 1'b0;
                err_nxt   = 1'b0;
                state_nxt = HOLD;
            end
            HOLD: begin
                // keep the device selected until the CPU phase ends
                if (!phi_0) begin
                    cs_nxt    = '0;
                    oe_nxt    = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_access_ctrl.sv
// Scoreboarded bench for bus_access_ctrl with a behavioural memory map model.
module tb_bus_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        phi_0 = 1'b0;
    logic [15:0] addr = 16'h0;
    logic        cpu_rw = 1'b1;
    logic [7:0]  mem_rdata;
    logic [3:0]  cs;
    logic        mem_oe, mem_we, rdy, bus_err;
    logic [7:0]  cpu_rdata;

    bus_access_ctrl #(
        .ADDR_W      (16),
        .DATA_W      (8),
        .NUM_REGIONS (4),
        .REGION_BASE ({16'h0000, 16'h4000, 16'h8000, 16'h0000}),
        .REGION_MASK ({16'hF000, 16'hF000, 16'h8000, 16'hE000}),
        .REGION_WAIT ({4'd5, 4'd3, 4'd2, 4'd0}),
        .REGION_RO   (4'b0010)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .phi_0     (phi_0),
        .addr      (addr),
        .cpu_rw    (cpu_rw),
        .mem_rdata (mem_rdata),
        .cs        (cs),
        .mem_oe    (mem_oe),
        .mem_we    (mem_we),
        .rdy       (rdy),
        .cpu_rdata (cpu_rdata),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    // device side: memories see the address the CPU presented at the latch edge
    logic [7:0]  dev_mem [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [15:0] bus_addr = 16'h0;
    logic [7:0]  wdata = 8'h0;

    assign mem_rdata = (mem_oe && cs != 4'b0) ? dev_mem[bus_addr] : 8'h00;
    always @(posedge clk) if (mem_we) dev_mem[bus_addr] <= wdata;

    typedef struct {
        int         id;
        logic [3:0] cs;
        logic       oe;
        logic       we;
        logic       err;
        int         low;
        logic [7:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   issued = 0;
    int   done_cnt = 0;
    bit   mon_en = 1'b1;
    logic [7:0] last_rdata = 8'h00;
    int   wait_tab[4] = '{0, 2, 3, 5};
    bit   ro_tab[4] = '{0, 1, 0, 0};

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (access %0d): got %h, expected %h", nm, id, act, exp);
        end
    endtask

    function automatic int ref_region(input logic [15:0] a);
        if (a < 16'h2000) return 0;
        if (a >= 16'h8000) return 1;
        if (a >= 16'h4000 && a < 16'h5000) return 2;
        if (a < 16'h1000) return 3;
        return -1;
    endfunction

    // monitor: an access ends when rdy returns high after a low stretch
    int  low_cnt = 0;
    bit  chk_pulse = 1'b0;
    int  pulse_id = 0;
    always @(negedge clk) begin
        if (rst || !mon_en) begin
            low_cnt   = 0;
            chk_pulse = 1'b0;
        end else begin
            if (chk_pulse) begin
                chk("mem_we width", pulse_id, mem_we, 0);
                chk("bus_err width", pulse_id, bus_err, 0);
                chk_pulse = 1'b0;
            end
            if (!rdy) begin
                low_cnt++;
            end else if (low_cnt != 0) begin
                if (sb.size() == 0) begin
                    chk("unexpected access", -1, 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("cs", e.id, cs, e.cs);
                    chk("mem_oe", e.id, mem_oe, e.oe);
                    chk("mem_we", e.id, mem_we, e.we);
                    chk("bus_err", e.id, bus_err, e.err);
                    chk("rdy low clks", e.id, low_cnt, e.low);
                    chk("cpu_rdata", e.id, cpu_rdata, e.rdata);
                    pulse_id = e.id;
                end
                done_cnt++;
                low_cnt   = 0;
                chk_pulse = 1'b1;
            end
        end
    end

    task automatic do_access(input logic [15:0] a, input logic rw, input logic [7:0] wd, input bit toggle);
        exp_t e;
        int   r;
        r       = ref_region(a);
        e.id    = issued;
        e.oe    = rw && (r >= 0);
        e.we    = 1'b0;
        e.err   = 1'b0;
        if (r >= 0) begin
            e.cs  = 4'(1 << r);
            e.low = wait_tab[r] + 1;
            if (!rw && ro_tab[r]) e.err = 1'b1;
            else if (!rw) e.we = 1'b1;
        end else begin
            e.cs  = 4'b0;
            e.low = 1;
            e.err = 1'b1;
        end
        if (rw) last_rdata = (r >= 0) ? ref_mem[a] : 8'hFF;
        if (e.we) ref_mem[a] = wd;
        e.rdata = last_rdata;
        sb.push_back(e);

        @(negedge clk);
        addr = a; cpu_rw = rw; bus_addr = a; wdata = wd; phi_0 = 1'b1;
        issued++;
        if (toggle) begin
            @(negedge clk);
            addr = 16'h1FFF; cpu_rw = 1'b0; phi_0 = 1'b0;
            @(negedge clk);
            phi_0 = 1'b1;
        end else begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            phi_0 = 1'b0;
        end
        for (int k = 0; k < 64 && done_cnt != issued; k++) @(negedge clk);
        if (done_cnt != issued) begin
            chk("completion timeout", e.id, done_cnt, issued);
            sb.delete();
            done_cnt = issued;
        end
        phi_0 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            dev_mem[i] = 8'($urandom);
            ref_mem[i] = dev_mem[i];
        end
        dev_mem[16'hFFFE] = 8'hEA;
        ref_mem[16'hFFFE] = 8'hEA;

        repeat (3) @(negedge clk);
        #1;
        chk("reset cs", -1, cs, 0);
        chk("reset rdy", -1, rdy, 1);
        chk("reset cpu_rdata", -1, cpu_rdata, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        do_access(16'h0000, 1'b0, 8'hAA, 1'b0);
        do_access(16'h0000, 1'b1, 8'h00, 1'b0);
        do_access(16'hFFFE, 1'b1, 8'h00, 1'b0);
        do_access(16'h8000, 1'b0, 8'h5C, 1'b0);
        do_access(16'h8000, 1'b1, 8'h00, 1'b0);
        do_access(16'h6000, 1'b1, 8'h00, 1'b0);
        do_access(16'h4001, 1'b1, 8'h00, 1'b1);

        for (int n = 0; n < 40; n++) begin
            logic [15:0] a;
            case ($urandom_range(0, 4))
                0: a = 16'($urandom_range(16'h0000, 16'h1FFF));
                1: a = 16'($urandom_range(16'h8000, 16'hFFFF));
                2: a = 16'($urandom_range(16'h4000, 16'h4FFF));
                3: a = 16'($urandom_range(16'h5000, 16'h7FFF));
                default: a = 16'($urandom);
            endcase
            do_access(a, 1'($urandom), 8'($urandom), 1'b0);
            if (n % 8 == 7) do_access(a, 1'b1, 8'h00, 1'b0);
        end

        // reset in the middle of a wait-stretched access
        @(negedge clk);
        mon_en = 1'b0;
        addr = 16'h4010; cpu_rw = 1'b1; bus_addr = 16'h4010; phi_0 = 1'b1;
        repeat (2) @(negedge clk);
        chk("pre-reset rdy", -1, rdy, 0);
        #1 rst = 1'b1;
        #1;
        chk("rst cs", -1, cs, 0);
        chk("rst mem_oe", -1, mem_oe, 0);
        chk("rst mem_we", -1, mem_we, 0);
        chk("rst rdy", -1, rdy, 1);
        chk("rst bus_err", -1, bus_err, 0);
        chk("rst cpu_rdata", -1, cpu_rdata, 0);
        phi_0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        last_rdata = 8'h00;
        @(negedge clk);
        mon_en = 1'b1;
        do_access(16'h4020, 1'b1, 8'h00, 1'b0);
        do_access(16'h1234, 1'b0, 8'h3C, 1'b0);
        do_access(16'h1234, 1'b1, 8'h00, 1'b0);

        chk("scoreboard drained", -1, sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_access_ctrl.md
# bus_access_ctrl

Parametrised 6502-side bus access controller between the CPU bus and the on-board memories and peripherals (SRAM, ROM, FDC registers). It replaces the fixed glue decode, SRAM at $0000-$1FFF write-gated by phi_0 and ROM at $8000-$FFFF, with a table of NUM_REGIONS address windows. Each window has its own wait-state count and write protection. The block runs a per-access state machine that drives chip selects, a one-cycle write strobe, RDY stretching, registered read data and an error flag for unmapped or protected accesses.

## Interface
Parameters:
- ADDR_W, 16, CPU address width
- DATA_W, 8, data width
- NUM_REGIONS, 4, number of decode windows (1..8)
- REGION_BASE, packed NUM_REGIONS*ADDR_W, window base; region i occupies bits [i*ADDR_W +: ADDR_W]
- REGION_MASK, packed NUM_REGIONS*ADDR_W, compare mask; match when (addr & mask) == (base & mask)
- REGION_WAIT, packed NUM_REGIONS*4, wait states per region (0..15)
- REGION_RO, NUM_REGIONS bits, 1 = write-protected region

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- phi_0  in  1  CPU phase clock from clock_gen, synchronous to clk
- addr  in  ADDR_W  CPU address
- cpu_rw  in  1  1 = read, 0 = write (6502 convention)
- mem_rdata  in  DATA_W  read data, OR of all selected devices
- cs  out  NUM_REGIONS  one-hot chip selects
- mem_oe  out  1  read enable to the selected device
- mem_we  out  1  write strobe, exactly one clk wide
- rdy  out  1  CPU RDY; low stalls the CPU
- cpu_rdata  out  DATA_W  registered read data
- bus_err  out  1  one-clk pulse for an unmapped access or a write to an RO region

## Operation
- States: IDLE, ACCESS, DONE, HOLD. phi_q is a registered copy of phi_0.
- IDLE: on the edge where phi_0=1 and phi_q=0:
  - latch addr and cpu_rw
  - decode: the lowest-index matching region wins
  - cs <= one-hot match; mem_oe <= read & mapped
  - cnt <= REGION_WAIT[match]; rdy <= 0; go to ACCESS
- ACCESS: if cnt != 0, cnt--. If cnt == 0:
  - read: cpu_rdata <= mem_rdata (or 8'hFF when unmapped)
  - write to a mapped non-RO region: mem_we <= 1
  - unmapped, or write to RO: bus_err <= 1 and no mem_we
  - rdy <= 1; go to DONE
- DONE: mem_we <= 0, bus_err <= 0; go to HOLD.
- HOLD: hold cs and mem_oe until phi_0=0 is sampled, then clear them and go to IDLE.
- A phi_0 rise seen in any state other than IDLE is ignored. The access completes with its latched address.
- Changes on addr/cpu_rw after the latch edge have no effect on the access in progress.
- Region overlap is legal; priority is by index.
- Reset (asynchronous, any state): state=IDLE, cs=0, mem_oe=0, mem_we=0, rdy=1, bus_err=0, cpu_rdata=0, cnt=0, phi_q=0.

## Timing
- E0 = the latch edge. cs and mem_oe are valid after E0, and rdy is low after E0.
- For wait count W: the capture/strobe edge is E(W+1), and rdy is high again after E(W+1). RDY is therefore low for W+1 clks.
- mem_rdata is sampled at least one clk after cs asserts. This covers the 1-cycle synchronous SRAM and ROM latency.
- mem_we and bus_err are high for exactly one clk, after E(W+1).
- cs drops one clk after phi_0=0 is first sampled in HOLD. If phi_0 is already low at DONE, cs is held for at least DONE plus one HOLD clk.
- No combinational path exists from inputs to outputs.

## Structure
- Package bus_pkg holds:
  - the state enumeration (IDLE/ACCESS/DONE/HOLD)
  - WAIT_W = 4
  - UNMAPPED_DATA = 8'hFF
  - helper functions to slice REGION_BASE, REGION_MASK and REGION_WAIT
- Sub-module addr_region_match: a combinational priority decoder from addr to one-hot match plus a valid flag. It is parametrised by NUM_REGIONS, ADDR_W, REGION_BASE and REGION_MASK.
- The FSM, wait counter and output registers live in bus_access_ctrl.

## Test plan
Bench configuration:
- region0: base 0000, mask E000, W=0 (SRAM)
- region1: base 8000, mask 8000, W=2, RO (ROM)
- region2: base 4000, mask F000, W=3 (FDC)
- region3: base 0000, mask F000, W=5

Scenarios:
- Write 8'hAA to 0000 -> cs=0001; rdy low 1 clk; mem_we one pulse after E1; SRAM model reads back AA; region3 not selected (priority).
- Read FFFE with mem_rdata=8'hEA -> cs=0010, rdy low 3 clks, cpu_rdata=EA after E3, bus_err=0.
- Write to 8000 -> cs=0010, no mem_we, bus_err pulse after E3.
- Read 6000 (unmapped) -> cs=0000, rdy low 1 clk, cpu_rdata=FF, bus_err pulse.
- Read 4001 with W=3, toggling addr to 1FFF mid-wait and issuing a second phi_0 rise during ACCESS -> cs stays 0100, the second rise is ignored, and rdy is low exactly 4 clks.
- Assert rst during ACCESS of a region2 access -> all outputs take reset values in the same time step; the next phi_0 rise starts a clean access.
